packet_out_stepper: RTL and testbench

Output-side buffer between the processor pipeline's packet egress and the 7-segment display stage. It accepts result packets over a valid/ready handshake into a small FIFO. It releases one packet to the display stage per debounced edge (rising or falling) of a manual step switch. This lets the operator walk through results one at a time while the pipeline runs at full clock rate.

---
 rtl/packet_out_stepper.sv | 118 +++++++++++
 tb/tb_packet_out_stepper.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_out_stepper.sv
// packet_out_stepper: egress FIFO that releases one packet to the display
// stage per debounced edge (either direction) of a manual step switch.
module packet_out_stepper #(
  parameter int PW     = 32,
  parameter int DEPTH  = 8,
  parameter int DB_CNT = 1000000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [PW-1:0]            IN_PACKET,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic                     SW,
  output logic [PW-1:0]            PACKET_OUT,
  output logic                     OUT_VALID,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int DBW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

  localparam logic [CW-1:0]  COUNT_FULL = CW'(DEPTH);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CNT - 1);

  logic [PW-1:0]  mem_q [DEPTH];

  logic           s1_q, s1_d;
  logic           s2_q, s2_d;
  logic           level_q, level_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  pkt_q, pkt_d;
  logic           valid_q, valid_d;

  logic           step;
  logic           push;
  logic           pop;

  // Synchronizer, debouncer, step detection and FIFO bookkeeping.
  always_comb begin
    s1_d     = SW;
    s2_d     = s1_q;
    level_d  = level_q;
    db_cnt_d = '0;
    step     = 1'b0;

    // Counter only runs while the synchronized switch disagrees with the
    // debounced level; any agreement clears it.
    if (s2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = s2_q;
        step    = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    // Both decisions use pre-edge occupancy: a full FIFO rejects a push even
    // when a pop happens on the same edge, and a packet pushed into an empty
    // FIFO cannot be popped on that same edge.
    push = IN_VALID && (count_q != COUNT_FULL);
    pop  = step && (count_q != '0);

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    pkt_d   = pop ? mem_q[rd_ptr_q] : pkt_q;
    valid_d = valid_q | pop;
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pkt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pkt_q    <= pkt_d;
      valid_q  <= valid_d;
    end
  end

  // FIFO storage; contents are don't-care after reset since pointers clear.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= IN_PACKET;
    end
  end

  assign IN_READY   = (count_q != COUNT_FULL);
  assign PACKET_OUT = pkt_q;
  assign OUT_VALID  = valid_q;
  assign COUNT      = count_q;

endmodule

// File: tb/tb_packet_out_stepper.sv
// Directed self-checking bench for packet_out_stepper (DB_CNT=4, DEPTH=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_packet_out_stepper;

  logic        CLK;
  logic        RST;
  logic [31:0] IN_PACKET;
  logic        IN_VALID;
  logic        IN_READY;
  logic        SW;
  logic [31:0] PACKET_OUT;
  logic        OUT_VALID;
  logic [3:0]  COUNT;

  int n_checks;
  int n_fail;

  packet_out_stepper #(
    .PW    (32),
    .DEPTH (8),
    .DB_CNT(4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_PACKET (IN_PACKET),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .SW        (SW),
    .PACKET_OUT(PACKET_OUT),
    .OUT_VALID (OUT_VALID),
    .COUNT     (COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic push(input logic [31:0] d);
    IN_VALID  = 1'b1;
    IN_PACKET = d;
    @(negedge CLK);
    IN_VALID  = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++;
    if (COUNT !== 4'd0 || IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || PACKET_OUT !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_init: COUNT=%0d IN_READY=%b OUT_VALID=%b PACKET_OUT=%h, want 0 1 0 0",
               COUNT, IN_READY, OUT_VALID, PACKET_OUT);
    end
    push(32'hAA);
    push(32'hBB);
    n_checks++;
    if (COUNT !== 4'd2) begin
      n_fail++;
      $display("FAIL reset_prefill: COUNT=%0d want 2", COUNT);
    end
    #2 RST = 1'b1;
    #1;
    n_checks++;
    if (COUNT !== 4'd0 || IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || PACKET_OUT !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_async: COUNT=%0d IN_READY=%b OUT_VALID=%b PACKET_OUT=%h, want 0 1 0 0",
               COUNT, IN_READY, OUT_VALID, PACKET_OUT);
    end
    #1 RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic_step;
    push(32'h11);
    push(32'h22);
    push(32'h33);
    n_checks++;
    if (COUNT !== 4'd3) begin
      n_fail++;
      $display("FAIL basic_count3: COUNT=%0d want 3", COUNT);
    end
    SW = 1'b1;
    repeat (5) @(negedge CLK);
    n_checks++;
    if (PACKET_OUT !== 32'h0 || OUT_VALID !== 1'b0 || COUNT !== 4'd3) begin
      n_fail++;
      $display("FAIL basic_edge5: PACKET_OUT=%h OUT_VALID=%b COUNT=%0d want 0 0 3",
               PACKET_OUT, OUT_VALID, COUNT);
    end
    @(negedge CLK);
    n_checks++;
    if (PACKET_OUT !== 32'h11 || OUT_VALID !== 1'b1 || COUNT !== 4'd2) begin
      n_fail++;
      $display("FAIL basic_rise: PACKET_OUT=%h OUT_VALID=%b COUNT=%0d want 11 1 2",
               PACKET_OUT, OUT_VALID, COUNT);
    end
    SW = 1'b0;
    repeat (6) @(negedge CLK);
    n_checks++;
    if (PACKET_OUT !== 32'h22 || COUNT !== 4'd1) begin
      n_fail++;
      $display("FAIL basic_fall: PACKET_OUT=%h COUNT=%0d want 22 1", PACKET_OUT, COUNT);
    end
    SW = 1'b1;
    repeat (6) @(negedge CLK);
    n_checks++;
    if (PACKET_OUT !== 32'h33 || COUNT !== 4'd0) begin
      n_fail++;
      $display("FAIL basic_drain: PACKET_OUT=%h COUNT=%0d want 33 0", PACKET_OUT, COUNT);
    end
  endtask

  task automatic test_full_wrap;
    logic [31:0] exp_q [8];
    for (int i = 0; i < 8; i++) push(32'hA0 + 32'(i));
    n_checks++;
    if (COUNT !== 4'd8 || IN_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL full_count: COUNT=%0d IN_READY=%b want 8 0", COUNT, IN_READY);
    end
    // Hold 0x99 against a full FIFO while a falling step is debounced.
    IN_VALID  = 1'b1;
    IN_PACKET = 32'h99;
    SW        = 1'b0;
    repeat (5) @(negedge CLK);
    n_checks++;
    if (COUNT !== 4'd8 || PACKET_OUT !== 32'h33) begin
      n_fail++;
      $display("FAIL full_reject: COUNT=%0d PACKET_OUT=%h want 8 33", COUNT, PACKET_OUT);
    end
    @(negedge CLK);
    n_checks++;
    if (COUNT !== 4'd7 || IN_READY !== 1'b1 || PACKET_OUT !== 32'hA0) begin
      n_fail++;
      $display("FAIL full_pop: COUNT=%0d IN_READY=%b PACKET_OUT=%h want 7 1 a0",
               COUNT, IN_READY, PACKET_OUT);
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    n_checks++;
    if (COUNT !== 4'd8) begin
      n_fail++;
      $display("FAIL full_accept99: COUNT=%0d want 8", COUNT);
    end
    for (int i = 0; i < 7; i++) exp_q[i] = 32'hA1 + 32'(i);
    exp_q[7] = 32'h99;
    for (int i = 0; i < 8; i++) begin
      SW = ~SW;
      repeat (6) @(negedge CLK);
      n_checks++;
      if (PACKET_OUT !== exp_q[i] || COUNT !== 4'(7 - i)) begin
        n_fail++;
        $display("FAIL wrap_pop%0d: PACKET_OUT=%h COUNT=%0d want %h %0d",
                 i, PACKET_OUT, COUNT, exp_q[i], 7 - i);
      end
    end
  endtask

  task automatic test_bounce;
    push(32'h5A);
    SW = 1'b1; repeat (3) @(negedge CLK);
    SW = 1'b0; repeat (2) @(negedge CLK);
    SW = 1'b1; repeat (3) @(negedge CLK);
    SW = 1'b0; repeat (2) @(negedge CLK);
    n_checks++;
    if (PACKET_OUT !== 32'h99 || COUNT !== 4'd1) begin
      n_fail++;
      $display("FAIL bounce_nostep: PACKET_OUT=%h COUNT=%0d want 99 1", PACKET_OUT, COUNT);
    end
    SW = 1'b1;
    repeat (5) @(negedge CLK);
    n_checks++;
    if (PACKET_OUT !== 32'h99 || COUNT !== 4'd1) begin
      n_fail++;
      $display("FAIL bounce_edge5: PACKET_OUT=%h COUNT=%0d want 99 1", PACKET_OUT, COUNT);
    end
    @(negedge CLK);
    n_checks++;
    if (PACKET_OUT !== 32'h5A || COUNT !== 4'd0) begin
      n_fail++;
      $display("FAIL bounce_step: PACKET_OUT=%h COUNT=%0d want 5a 0", PACKET_OUT, COUNT);
    end
    push(32'h66);
    repeat (8) @(negedge CLK);
    n_checks++;
    if (PACKET_OUT !== 32'h5A || COUNT !== 4'd1) begin
      n_fail++;
      $display("FAIL bounce_single: PACKET_OUT=%h COUNT=%0d want 5a 1", PACKET_OUT, COUNT);
    end
  endtask

  task automatic test_empty_step;
    SW = 1'b0;
    repeat (6) @(negedge CLK);
    n_checks++;
    if (PACKET_OUT !== 32'h66 || COUNT !== 4'd0) begin
      n_fail++;
      $display("FAIL empty_prep: PACKET_OUT=%h COUNT=%0d want 66 0", PACKET_OUT, COUNT);
    end
    SW = 1'b1;
    repeat (6) @(negedge CLK);
    n_checks++;
    if (PACKET_OUT !== 32'h66 || OUT_VALID !== 1'b1 || COUNT !== 4'd0) begin
      n_fail++;
      $display("FAIL empty_step: PACKET_OUT=%h OUT_VALID=%b COUNT=%0d want 66 1 0",
               PACKET_OUT, OUT_VALID, COUNT);
    end
    push(32'h44);
    repeat (4) @(negedge CLK);
    n_checks++;
    if (PACKET_OUT !== 32'h66 || COUNT !== 4'd1) begin
      n_fail++;
      $display("FAIL empty_notqueued: PACKET_OUT=%h COUNT=%0d want 66 1", PACKET_OUT, COUNT);
    end
    SW = 1'b0;
    repeat (6) @(negedge CLK);
    n_checks++;
    if (PACKET_OUT !== 32'h44 || COUNT !== 4'd0) begin
      n_fail++;
      $display("FAIL empty_later: PACKET_OUT=%h COUNT=%0d want 44 0", PACKET_OUT, COUNT);
    end
  endtask

  task automatic test_reset_mid_debounce;
    push(32'h71);
    push(32'h72);
    push(32'h73);
    n_checks++;
    if (COUNT !== 4'd3) begin
      n_fail++;
      $display("FAIL rstdb_prefill: COUNT=%0d want 3", COUNT);
    end
    SW = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    #1;
    n_checks++;
    if (COUNT !== 4'd0 || IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || PACKET_OUT !== 32'h0) begin
      n_fail++;
      $display("FAIL rstdb_clear: COUNT=%0d IN_READY=%b OUT_VALID=%b PACKET_OUT=%h want 0 1 0 0",
               COUNT, IN_READY, OUT_VALID, PACKET_OUT);
    end
    #1 RST = 1'b0;
    repeat (6) @(negedge CLK);
    n_checks++;
    if (PACKET_OUT !== 32'h0 || OUT_VALID !== 1'b0 || COUNT !== 4'd0) begin
      n_fail++;
      $display("FAIL rstdb_emptystep: PACKET_OUT=%h OUT_VALID=%b COUNT=%0d want 0 0 0",
               PACKET_OUT, OUT_VALID, COUNT);
    end
    // The held-high switch must have flipped the level, so a falling step pops.
    push(32'h88);
    repeat (4) @(negedge CLK);
    n_checks++;
    if (PACKET_OUT !== 32'h0 || COUNT !== 4'd1) begin
      n_fail++;
      $display("FAIL rstdb_nostep: PACKET_OUT=%h COUNT=%0d want 0 1", PACKET_OUT, COUNT);
    end
    SW = 1'b0;
    repeat (6) @(negedge CLK);
    n_checks++;
    if (PACKET_OUT !== 32'h88 || OUT_VALID !== 1'b1 || COUNT !== 4'd0) begin
      n_fail++;
      $display("FAIL rstdb_fallstep: PACKET_OUT=%h OUT_VALID=%b COUNT=%0d want 88 1 0",
               PACKET_OUT, OUT_VALID, COUNT);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    RST       = 1'b1;
    SW        = 1'b0;
    IN_VALID  = 1'b0;
    IN_PACKET = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    test_reset();
    test_basic_step();
    test_full_wrap();
    test_bounce();
    test_empty_step();
    test_reset_mid_debounce();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
